// File: rtl/msg_sequencer.sv
// Character-stream sequencer: replays one of NUM_MSG loadable messages, one symbol
// per beat, over a valid/ready port with one-shot/loop modes and end-of-message flag.
module msg_sequencer #(
  parameter  int DATA_W  = 8,
  parameter  int NUM_MSG = 4,
  parameter  int MAX_LEN = 16,
  localparam int SEL_W   = $clog2(NUM_MSG),
  localparam int IDX_W   = $clog2(MAX_LEN),
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [SEL_W-1:0]  select,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err_empty,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_msg,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_len_we,
  input  logic [LEN_W-1:0]  cfg_len
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem   [NUM_MSG][MAX_LEN];
  logic [LEN_W-1:0]  len_q [NUM_MSG];
  logic [SEL_W-1:0]  cur_msg;
  logic              cur_loop;
  logic [IDX_W-1:0]  idx;

  logic              xfer, is_last, sel_ok;
  logic              load, advance, err_nxt;
  logic              cfg_block;
  logic [LEN_W-1:0]  cfg_len_sat;

  assign busy      = (state == RUN);
  assign out_valid = busy;
  assign xfer      = out_valid & out_ready;
  assign sel_ok    = (len_q[select] != '0);
  assign is_last   = busy && ((LEN_W'(idx) + LEN_W'(1)) == len_q[cur_msg]);
  assign out_last  = is_last;
  // Read is stable mid-play: writes to cur_msg are blocked while busy.
  assign out_data  = busy ? mem[cur_msg][idx] : '0;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !stop && sel_ok) state_nxt = RUN;
      RUN: begin
        if (stop)
          state_nxt = IDLE;
        else if (xfer && is_last && !(cur_loop && sel_ok))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: control outputs ----------------
  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (sel_ok) load    = 1'b1;
          else        err_nxt = 1'b1;
        end
      end
      RUN: begin
        // stop wins over a loop wrap; a same-cycle transfer still counts.
        if (!stop && xfer) begin
          if (!is_last)      advance = 1'b1;
          else if (cur_loop) begin
            if (sel_ok) load    = 1'b1;
            else        err_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------- Playback datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_msg   <= '0;
      cur_loop  <= 1'b0;
      idx       <= '0;
      err_empty <= 1'b0;
    end else begin
      err_empty <= err_nxt;
      if (load) begin
        cur_msg <= select;
        idx     <= '0;
        if (state == IDLE) cur_loop <= loop;
      end else if (advance) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // ---------------- Configuration ----------------
  assign cfg_block   = busy && (cfg_msg == cur_msg);
  assign cfg_len_sat = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

  // Symbol storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (cfg_we && !cfg_block) mem[cfg_msg][cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < NUM_MSG; m++) len_q[m] <= '0;
    end else if (cfg_len_we && !cfg_block) begin
      len_q[cfg_msg] <= cfg_len_sat;
    end
  end

endmodule

// File: tb/tb_msg_sequencer.sv
// Self-checking bench for msg_sequencer: expected symbol streams are built from
// a plain array model of message memory/lengths and consumed beat by beat.
module tb_msg_sequencer;
  localparam int DATA_W = 8, NUM_MSG = 4, MAX_LEN = 16;
  localparam int SEL_W = 2, IDX_W = 4, LEN_W = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [SEL_W-1:0]  select;
  logic              start, stop, loop;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_ready, out_last, busy, err_empty;
  logic              cfg_we, cfg_len_we;
  logic [SEL_W-1:0]  cfg_msg;
  logic [IDX_W-1:0]  cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic [LEN_W-1:0]  cfg_len;

  msg_sequencer #(.DATA_W(DATA_W), .NUM_MSG(NUM_MSG), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .select(select), .start(start), .stop(stop),
    .loop(loop), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err_empty(err_empty), .cfg_we(cfg_we),
    .cfg_msg(cfg_msg), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_mem [NUM_MSG][MAX_LEN];
  int         m_len [NUM_MSG];
  logic [7:0] exq_d [$];
  bit         exq_l [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int m, input int a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_msg = SEL_W'(m); cfg_addr = IDX_W'(a); cfg_data = d;
    step();
    cfg_we = 1'b0;
    m_mem[m][a] = d;
  endtask

  task automatic cfg_ln(input int m, input int n);
    cfg_len_we = 1'b1; cfg_msg = SEL_W'(m); cfg_len = LEN_W'(n);
    step();
    cfg_len_we = 1'b0;
    m_len[m] = (n > MAX_LEN) ? MAX_LEN : n;
  endtask

  task automatic push_slot(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      exq_d.push_back(m_mem[s][i]);
      exq_l.push_back(i == m_len[s] - 1);
    end
  endtask

  task automatic start_play(input int s, input bit lp);
    select = SEL_W'(s); loop = lp; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_data"},  32'(out_data), 0);
    chk({tag, "_last"},  32'(out_last), 0);
  endtask

  // rmode: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
  // cfg_at >= 0 issues a write to the playing slot, then to slot 2, mid-play.
  task automatic drive(input string tag, input int nbeats, input int rmode,
                       input bit use_stop, input int cfg_at);
    int beats = 0;
    int cyc = 0;
    bit r;
    while (beats < nbeats && cyc < 500) begin
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_busy"},  32'(busy), 1);
      chk({tag, "_data"},  32'(out_data), 32'(exq_d[0]));
      chk({tag, "_last"},  32'(out_last), 32'(exq_l[0]));
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      stop = (use_stop && r && beats == nbeats - 1);
      cfg_we = 1'b0; cfg_len_we = 1'b0;
      if (cyc == cfg_at) begin
        cfg_we = 1'b1; cfg_msg = 2'd0; cfg_addr = 4'd3; cfg_data = 8'hFF;
      end else if (cfg_at >= 0 && cyc == cfg_at + 1) begin
        cfg_we = 1'b1; cfg_msg = 2'd2; cfg_addr = 4'd0; cfg_data = 8'hA5;
        cfg_len_we = 1'b1; cfg_len = 5'd1;
        m_mem[2][0] = 8'hA5; m_len[2] = 1;
      end
      out_ready = r;
      step();
      stop = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0;
      if (r) begin
        void'(exq_d.pop_front());
        void'(exq_l.pop_front());
        beats++;
      end
      cyc++;
    end
    chk({tag, "_beats"}, 32'(beats), 32'(nbeats));
  endtask

  initial begin
    reset_n = 1'b0; select = '0; start = 1'b0; stop = 1'b0; loop = 1'b0;
    out_ready = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0; cfg_msg = '0;
    cfg_addr = '0; cfg_data = '0; cfg_len = '0;
    for (int m = 0; m < NUM_MSG; m++) m_len[m] = 0;
    step(); step();
    chk_idle("reset");
    chk("reset_err", 32'(err_empty), 0);
    reset_n = 1'b1;
    step();

    begin
      logic [7:0] s0 [9];
      logic [7:0] s1 [7];
      s0 = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
      s1 = '{8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
      for (int i = 0; i < 9; i++) cfg_wr(0, i, s0[i]);
      cfg_ln(0, 9);
      for (int i = 0; i < 7; i++) cfg_wr(1, i, s1[i]);
      cfg_ln(1, 7);
    end

    // One-shot, full throughput, then back-to-back one-shot under backpressure.
    push_slot(0, 9);
    start_play(0, 1'b0);
    drive("oneshot", 9, 0, 1'b0, -1);
    chk_idle("oneshot_end");
    push_slot(0, 9);
    start_play(0, 1'b0);
    drive("stall", 9, 1, 1'b0, -1);
    chk_idle("stall_end");

    // Loop: select moves to slot 1 mid-message, wraps without bubbles, then stop.
    push_slot(0, 9); push_slot(1, 7); push_slot(1, 3);
    start_play(0, 1'b1);
    select = 2'd1;
    drive("loop", 19, 0, 1'b1, -1);
    chk_idle("loop_stop");
    exq_d.delete(); exq_l.delete();

    // Empty slot refused.
    start_play(2, 1'b0);
    chk("err_pulse", 32'(err_empty), 1);
    chk("err_busy",  32'(busy), 0);
    chk("err_valid", 32'(out_valid), 0);
    step();
    chk("err_clear", 32'(err_empty), 0);

    // Random contents and length on slot 3 with random backpressure.
    begin
      int n = $urandom_range(1, MAX_LEN);
      for (int i = 0; i < n; i++) cfg_wr(3, i, 8'($urandom));
      cfg_ln(3, n);
      push_slot(3, n);
      start_play(3, 1'b0);
      drive("rand", n, 2, 1'b0, -1);
      chk_idle("rand_end");
    end

    // Over-length value saturates to MAX_LEN.
    for (int i = 0; i < MAX_LEN; i++) cfg_wr(3, i, 8'($urandom));
    cfg_ln(3, MAX_LEN + 5);
    push_slot(3, MAX_LEN);
    start_play(3, 1'b0);
    drive("clamp", MAX_LEN, 2, 1'b0, -1);
    chk_idle("clamp_end");

    // Config writes during playback: playing slot protected, other slot updated.
    push_slot(0, 9);
    start_play(0, 1'b0);
    drive("cfgplay", 9, 0, 1'b0, 2);
    chk_idle("cfgplay_end");
    push_slot(2, 1);
    start_play(2, 1'b0);
    drive("slot2", 1, 0, 1'b0, -1);
    chk_idle("slot2_end");

    // Asynchronous reset mid-message wipes lengths.
    push_slot(0, 9);
    start_play(0, 1'b0);
    drive("prerst", 4, 0, 1'b0, -1);
    reset_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_err", 32'(err_empty), 0);
    exq_d.delete(); exq_l.delete();
    for (int m = 0; m < NUM_MSG; m++) m_len[m] = 0;
    step();
    reset_n = 1'b1;
    step();
    start_play(0, 1'b0);
    chk("postrst_err",  32'(err_empty), 1);
    chk("postrst_busy", 32'(busy), 0);
    step();
    chk("postrst_clear", 32'(err_empty), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
